// File: rtl/sid_seq_pkg.sv
// Shared types and constants for the SID note sequencer.
// Holds the FSM state encoding, the rest-note marker and the step-tick counter width.
package sid_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        GATE_ON  = 2'd2,
        GATE_OFF = 2'd3
    } seq_state_t;

    localparam logic [15:0] REST_WORD = 16'h0000;

    // 9 bits so a 256-tick step (tempo=255) is countable without wrapping.
    localparam int STEP_CNT_W = 9;

endpackage

// File: rtl/sid_tick_gen.sv
// Sequencer tick generator: free-running 0..PRESCALE-1 counter with a one-cycle
// tick on the terminal count. Runs only while enabled; clr has priority.
module sid_tick_gen #(
    parameter int PRESCALE = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign tick = en & ~clr & (r_cnt == LAST);

endmodule

// File: rtl/sid_note_sequencer.sv
// Loop-pattern note sequencer feeding sid_voice frequency and gate.
// Steps through a small pattern memory at a fixed tick rate, retriggering the gate per note.
module sid_note_sequencer #(
    parameter int STEPS    = 8,
    parameter int PRESCALE = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(STEPS)-1:0]   wr_addr,
    input  logic [15:0]                wr_data,
    input  logic [$clog2(STEPS):0]     length,
    input  logic [7:0]                 tempo,
    input  logic [7:0]                 gate_len,
    input  logic [7:0]                 base_waveform,
    input  logic                       start,
    input  logic                       stop,
    output logic [15:0]                frequency,
    output logic [7:0]                 waveform,
    output logic [$clog2(STEPS)-1:0]   step_idx,
    output logic                       step_strobe,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    import sid_seq_pkg::*;

    localparam int AW = $clog2(STEPS);
    localparam int LW = AW + 1;

    seq_state_t              r_state;
    seq_state_t              w_next;
    logic [15:0]             r_mem [STEPS];
    logic [15:0]             r_freq;
    logic [AW-1:0]           r_step;
    logic                    r_gate;
    logic                    r_rest;
    logic [STEP_CNT_W-1:0]   r_tcnt;

    logic                    w_tick;
    logic                    w_clr_tick;
    logic                    w_enter_load;
    logic [AW-1:0]           w_load_idx;
    logic [LW-1:0]           w_eff_len;
    logic [LW-1:0]           w_step_plus;
    logic [AW-1:0]           w_step_next;
    logic [7:0]              w_g;
    logic [STEP_CNT_W-1:0]   w_tcnt_inc;
    logic [STEP_CNT_W-1:0]   w_step_ticks;
    logic [15:0]             w_load_word;
    logic                    w_unused;

    sid_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (r_state != IDLE),
        .clr  (w_clr_tick),
        .tick (w_tick)
    );

    // Loop length: 0 behaves as 1, anything beyond the memory depth is clamped.
    always_comb begin
        w_eff_len = length;
        if (length == '0) begin
            w_eff_len = LW'(1);
        end else if (length > LW'(STEPS)) begin
            w_eff_len = LW'(STEPS);
        end
    end

    assign w_step_plus  = LW'(r_step) + LW'(1);
    assign w_step_next  = (w_step_plus >= w_eff_len) ? '0 : w_step_plus[AW-1:0];
    assign w_g          = (gate_len < tempo) ? gate_len : tempo;
    assign w_tcnt_inc   = r_tcnt + STEP_CNT_W'(1);
    assign w_step_ticks = {1'b0, tempo} + STEP_CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_clr_tick   = 1'b0;
        w_enter_load = 1'b0;
        w_load_idx   = r_step;
        if (stop) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_next       = LOAD;
                        w_clr_tick   = 1'b1;
                        w_enter_load = 1'b1;
                        w_load_idx   = '0;
                    end
                end
                LOAD: begin
                    w_clr_tick = 1'b1;
                    w_next     = ((w_g != 8'd0) && !r_rest) ? GATE_ON : GATE_OFF;
                end
                GATE_ON: begin
                    // >= so a gate_len/tempo lowered mid-note still ends the gate.
                    if (w_tick && (w_tcnt_inc >= {1'b0, w_g})) begin
                        w_next = GATE_OFF;
                    end
                end
                GATE_OFF: begin
                    if (w_tick && (w_tcnt_inc >= w_step_ticks)) begin
                        w_next       = LOAD;
                        w_enter_load = 1'b1;
                        w_load_idx   = w_step_next;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    assign w_load_word = r_mem[w_load_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                r_mem[i] <= REST_WORD;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Frequency and step index update on the edge into LOAD so they are valid during LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_freq <= '0;
            r_step <= '0;
            r_rest <= 1'b0;
            r_gate <= 1'b0;
            r_tcnt <= '0;
        end else begin
            r_gate <= (w_next == GATE_ON);
            if (w_enter_load) begin
                r_step <= w_load_idx;
                r_rest <= (w_load_word == REST_WORD);
                if (w_load_word != REST_WORD) begin
                    r_freq <= w_load_word;
                end
            end
            if (r_state == LOAD) begin
                r_tcnt <= '0;
            end else if (w_tick && ((r_state == GATE_ON) || (r_state == GATE_OFF))) begin
                r_tcnt <= w_tcnt_inc;
            end
        end
    end

    assign w_unused    = base_waveform[0];
    assign frequency   = r_freq;
    assign waveform    = {base_waveform[7:1], r_gate};
    assign step_idx    = r_step;
    assign step_strobe = (r_state == LOAD);
    assign busy        = (r_state != IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_sid_note_sequencer.sv
// Self-checking bench for sid_note_sequencer with PRESCALE=4, STEPS=8.
// Expected {step_idx, frequency} pairs are queued at stimulus time and popped on each step_strobe.
module tb_sid_note_sequencer;

  localparam int STEPS = 8;
  localparam int PRESCALE = 4;
  localparam int AW = $clog2(STEPS);
  localparam int W = AW + 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [AW:0] length = '0;
  logic [7:0] tempo = '0;
  logic [7:0] gate_len = '0;
  logic [7:0] base_waveform = '0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [15:0] frequency;
  logic [7:0] waveform;
  logic [AW-1:0] step_idx;
  logic step_strobe;
  logic busy;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] m [STEPS];

  int cyc = 0;
  int last_cyc = 0;
  int hi_cnt = 0;
  bit have_prev = 0;
  bit chk_period = 0;
  bit chk_gate = 0;
  int exp_period = 0;
  int exp_gate = 0;

  sid_note_sequencer #(.STEPS(STEPS), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .length(length), .tempo(tempo), .gate_len(gate_len), .base_waveform(base_waveform),
    .start(start), .stop(stop), .frequency(frequency), .waveform(waveform),
    .step_idx(step_idx), .step_strobe(step_strobe), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need $finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // driver tasks
  task automatic push(input int s, input logic [15:0] f);
    exp_q.push_back({AW'(s), f});
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic wait_strobe();
    int n;
    bit got;
    got = 0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      got = step_strobe;
    end
    check("strobe_timeout", got, 1);
  endtask

  task automatic set_timing(input int t, input int g);
    tempo = 8'(t); gate_len = 8'(g);
    exp_period = (t + 1) * PRESCALE + 1;
    exp_gate = ((g < t) ? g : t) * PRESCALE;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (!busy) begin
      have_prev = 0; hi_cnt = 0;
    end else if (step_strobe) begin
      if (have_prev && chk_period) check("step_period", cyc - last_cyc, exp_period);
      if (have_prev && chk_gate) check("gate_high_cycles", hi_cnt, exp_gate);
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_step_freq", {step_idx, frequency}, e);
      end
      have_prev = 1; last_cyc = cyc; hi_cnt = 0;
    end else if (waveform[0]) begin
      hi_cnt++;
    end
  end

  initial begin
    int hc;
    for (int i = 0; i < STEPS; i++) m[i] = 16'((i + 1) * 16'h1111);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_freq", frequency, 16'h0);
    check("rst_waveform", waveform, 8'h0);
    check("rst_step", step_idx, 0);
    check("rst_strobe", step_strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    base_waveform = 8'h41;

    // basic loop
    wr(0, 16'h1000); wr(1, 16'h2000); wr(2, 16'h3000);
    length = 3; set_timing(3, 2);
    chk_period = 1; chk_gate = 1;
    push(0, 16'h1000); push(1, 16'h2000); push(2, 16'h3000); push(0, 16'h1000); push(1, 16'h2000);
    pulse_start();
    check("load_busy", busy, 1);
    check("load_strobe", step_strobe, 1);
    check("load_gate_low", waveform, 8'h40);
    @(negedge clk);
    check("gate_rise", waveform, 8'h41);
    repeat (4) wait_strobe();
    pulse_stop();
    check("stop_held_freq", frequency, 16'h2000);
    check("stop_held_step", step_idx, 1);

    // gate clamp
    set_timing(3, 10);
    push(0, 16'h1000); push(1, 16'h2000); push(2, 16'h3000);
    pulse_start();
    repeat (2) wait_strobe();
    pulse_stop();

    // restart from step 0, then stop during GATE_ON
    push(0, 16'h1000);
    set_timing(3, 2);
    pulse_start();
    check("restart_step", step_idx, 0);
    check("restart_freq", frequency, 16'h1000);
    repeat (3) @(negedge clk);
    check("gate_on_before_stop", waveform[0], 1);
    pulse_stop();
    check("stop_busy", busy, 0);
    check("stop_gate", waveform[0], 0);
    check("stop_freq", frequency, 16'h1000);

    // start and stop together while idle
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_state", dbg_state, 0);
    @(negedge clk);
    check("startstop_strobe", step_strobe, 0);

    // rest step
    wr(1, 16'h0000);
    chk_gate = 0;
    push(0, 16'h1000); push(1, 16'h1000); push(2, 16'h3000); push(0, 16'h1000);
    pulse_start();
    wait_strobe();
    hc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (waveform[0]) hc++;
    end
    check("rest_gate_cycles", hc, 0);
    check("rest_freq_held", frequency, 16'h1000);
    repeat (2) wait_strobe();
    pulse_stop();
    wr(1, 16'h2000);

    // silent steps (gate_len = 0)
    set_timing(3, 0);
    chk_gate = 1;
    push(0, 16'h1000); push(1, 16'h2000); push(2, 16'h3000);
    pulse_start();
    repeat (2) wait_strobe();
    pulse_stop();

    // length boundaries
    for (int i = 0; i < STEPS; i++) wr(i, m[i]);
    set_timing(1, 1);
    length = 0;
    repeat (3) push(0, m[0]);
    pulse_start();
    repeat (2) wait_strobe();
    pulse_stop();

    length = 15;
    for (int i = 0; i < 10; i++) push(i % STEPS, m[i % STEPS]);
    pulse_start();
    repeat (9) wait_strobe();
    pulse_stop();

    length = 8;
    for (int i = 0; i < 6; i++) push(i, m[i]);
    push(0, m[0]);
    pulse_start();
    repeat (5) wait_strobe();
    check("len_shrink_at_step", step_idx, 5);
    length = 2;
    wait_strobe();
    pulse_stop();

    // live pattern write
    length = 3;
    push(0, m[0]); push(1, m[1]); push(2, 16'hBEEF); push(0, m[0]);
    pulse_start();
    wr(2, 16'hBEEF);
    repeat (3) wait_strobe();
    pulse_stop();

    // asynchronous reset mid-gate
    push(0, m[0]);
    pulse_start();
    repeat (3) @(negedge clk);
    check("pre_rst_gate", waveform[0], 1);
    #2 rst = 1'b1;
    #1;
    check("arst_waveform", waveform, 8'h40);
    check("arst_freq", frequency, 16'h0);
    check("arst_step", step_idx, 0);
    check("arst_strobe", step_strobe, 0);
    check("arst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;

    // memory cleared by reset: entry 0 is now a rest
    length = 1;
    push(0, 16'h0000);
    pulse_start();
    check("cleared_mem_freq", frequency, 16'h0);
    @(negedge clk);
    check("cleared_mem_gate", waveform[0], 0);
    pulse_stop();

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
